// File: rtl/i2s_unit_core_pkg.sv
// Shared constants, rate codes, FSM states and the rate-to-half-period lookup.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_unit_core_pkg;

  localparam int MCLK_PERIOD    = 10;  // master clock period in ns
  localparam int I2S_FRAME_BITS = 64;

  typedef enum logic [1:0] {
    RATE_DIV8  = 2'b00,
    RATE_DIV4  = 2'b01,
    RATE_DIV2  = 2'b10,
    RATE_DIV2B = 2'b11
  } rate_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // Half-period of sck in master clocks for a given rate code.
  function automatic logic [2:0] half_of(input logic [1:0] code);
    case (rate_e'(code))
      RATE_DIV8: return 3'd4;
      RATE_DIV4: return 3'd2;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/i2s_if.sv
// Bundles the I2S serial pins so monitors can observe them as one unit.
// Latency: none, pure wiring.
// Backpressure: none, the master stream cannot be stalled.
interface i2s_if (
  input logic clk,
  input logic rst_n
);
  logic sdo;
  logic sck;
  logic ws;
endinterface

// File: rtl/i2s_sck_divider.sv
// Generates sck from the master clock: HALF clocks low, then HALF clocks high.
// Latency: sck starts low on the first enabled clock; bit_end flags the last clock of each bit.
// Backpressure: none; deasserting en forces sck low and clears the phase counter.
module i2s_sck_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] half,
  output logic       sck,
  output logic       bit_end
);

  logic [2:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       half_end;

  // bit_end is the last clock of the high phase: sck falls on the following edge
  assign half_end = en && (cnt_q == (half - 3'd1));
  assign bit_end  = half_end && sck_q;
  assign sck      = sck_q;

  // Phase counter and sck toggle at the end of every half period
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en) begin
      cnt_d = 3'd0;
      sck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = 3'd0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/i2s_unit_core.sv
// I2S master serialiser: 24-bit stereo in 64-bit frames, one req_out pulse per frame fetched.
// Latency: PLAY starts the clock after play_in; first bit (left MSB) leads immediately with sck low.
// Backpressure: none; a missing tick_in just replays the stale holding register.
module i2s_unit_core
  import i2s_unit_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_in,
  input  logic        tick_in,
  input  logic [23:0] audio_in_0,
  input  logic [23:0] audio_in_1,
  input  logic        cfg_in,
  input  logic [31:0] cfg_reg_in,
  output logic        req_out,
  output logic        ws_out,
  output logic        sck_out,
  output logic        sdo_out
);

  state_e      state_q, state_d;
  logic [47:0] hold_q;
  logic [47:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  rate_q;
  logic [2:0]  half_q, half_d;
  logic        req_q, req_d;
  logic        bit_end;
  logic        playing;
  logic        data_slot;
  logic        unused_cfg;

  assign unused_cfg = ^cfg_reg_in[31:2];

  assign playing   = (state_q == ST_PLAY);
  // bit_cnt 24..31 and 56..63 are the zero pad slots
  assign data_slot = (bit_cnt_q[4:3] != 2'b11);

  i2s_sck_divider u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (playing),
    .half    (half_q),
    .sck     (sck_out),
    .bit_end (bit_end)
  );

  // ws leads the right word by one bit and drops one bit before the next left word
  assign ws_out  = playing && (bit_cnt_q >= 6'd31) && (bit_cnt_q != 6'd63);
  assign sdo_out = playing && data_slot && shift_q[47];
  assign req_out = req_q;

  // Next-state: frame start/reload, shifting, bit counting and divider rate hand-over
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    half_d    = half_q;
    req_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        half_d = half_of(rate_q);
        if (play_in) begin
          state_d   = ST_PLAY;
          shift_d   = hold_q;
          bit_cnt_d = 6'd0;
          req_d     = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (data_slot) shift_d = {shift_q[46:0], 1'b0};
          if (bit_cnt_q == 6'(I2S_FRAME_BITS - 1)) begin
            half_d = half_of(rate_q);
            if (play_in) begin
              shift_d = hold_q;
              req_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath, holding and config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 48'h0;
      bit_cnt_q <= 6'd0;
      half_q    <= 3'd4;
      req_q     <= 1'b0;
      hold_q    <= 48'h0;
      rate_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      half_q    <= half_d;
      req_q     <= req_d;
      if (tick_in) hold_q <= {audio_in_0, audio_in_1};
      if (cfg_in)  rate_q <= cfg_reg_in[1:0];
    end
  end

endmodule

// File: tb/tb_i2s_unit_core.sv
// Directed bench for the I2S serialiser: frame content, ws pattern, rates, stop and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2s_unit_core;
  import i2s_unit_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        play_in;
  logic        tick_in;
  logic [23:0] audio_in_0;
  logic [23:0] audio_in_1;
  logic        cfg_in;
  logic [31:0] cfg_reg_in;
  logic        req_out;
  logic        ws_out;
  logic        sck_out;
  logic        sdo_out;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

  i2s_unit_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_in    (play_in),
    .tick_in    (tick_in),
    .audio_in_0 (audio_in_0),
    .audio_in_1 (audio_in_1),
    .cfg_in     (cfg_in),
    .cfg_reg_in (cfg_reg_in),
    .req_out    (req_out),
    .ws_out     (ws_out),
    .sck_out    (sck_out),
    .sdo_out    (sdo_out)
  );

  i2s_if pins (.clk(clk), .rst_n(rst_n));
  assign pins.sdo = sdo_out;
  assign pins.sck = sck_out;
  assign pins.ws  = ws_out;

  initial clk = 1'b0;
  always #(MCLK_PERIOD / 2) clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  // Called on the first clock of a frame; returns on the first clock after it.
  task automatic get_frame(output logic [63:0] sd, output logic [63:0] wsv,
                           output int clks, output int nreq, output int perr);
    logic ps, psdo, pws;
    int   b;
    sd = '0; wsv = '0; clks = 0; nreq = 0; perr = 0; b = 0;
    ps = pins.sck; psdo = pins.sdo; pws = pins.ws;
    if (req_out) nreq++;
    while (clks < 2000) begin
      step(1);
      clks++;
      if (!ps && pins.sck) begin
        if (b < 64) begin
          sd[63-b]  = pins.sdo;
          wsv[63-b] = pins.ws;
        end
        b++;
      end
      // sdo and ws may only move while sck is low
      if (pins.sck && ((pins.sdo != psdo) || (pins.ws != pws))) perr++;
      if (ps && !pins.sck && b == 64) break;
      if (req_out) nreq++;
      ps = pins.sck; psdo = pins.sdo; pws = pins.ws;
    end
  endtask

  task automatic cfg_pulse(input int dly, input logic [31:0] w);
    step(dly);
    cfg_in = 1'b1; cfg_reg_in = w;
    step(1);
    cfg_in = 1'b0;
  endtask

  task automatic tick_pulse(input int dly, input logic [23:0] l, input logic [23:0] r);
    step(dly);
    tick_in = 1'b1; audio_in_0 = l; audio_in_1 = r;
    step(1);
    tick_in = 1'b0;
  endtask

  logic [63:0] sd, wsv;
  int clks, nreq, perr, cnt;

  initial begin
    rst_n = 1'b0; play_in = 1'b0; tick_in = 1'b0; cfg_in = 1'b0;
    audio_in_0 = '0; audio_in_1 = '0; cfg_reg_in = '0;
    step(3);
    chk("reset_outs", 64'({req_out, ws_out, sck_out, sdo_out}), 64'h0);
    rst_n = 1'b1;

    // 1: idle with play low
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (req_out || ws_out || sck_out || sdo_out) cnt++;
    end
    chk("idle_quiet", 64'(cnt), 64'd0);

    // 2: rate 00 (upper cfg bits ignored), one sample, start playing
    cfg_pulse(0, 32'hFFFF_FFFC);
    tick_pulse(0, 24'hA5A5A5, 24'h5A5A5A);
    play_in = 1'b1;
    chk("req_before_play", 64'(req_out), 64'd0);
    step(1);
    chk("req_after_play", 64'(req_out), 64'd1);
    chk("sck_starts_low", 64'(sck_out), 64'd0);
    fork
      get_frame(sd, wsv, clks, nreq, perr);
      cfg_pulse(20, 32'h1);  // lands mid-frame: must not affect this frame
    join
    chk("f1_data", sd, frame_of(24'hA5A5A5, 24'h5A5A5A));
    chk("f1_ws", wsv, WS_EXP);
    chk("f1_len", 64'(clks), 64'd512);
    chk("f1_req", 64'(nreq), 64'd1);
    chk("f1_proto", 64'(perr), 64'd0);

    // 3: rate 01 then 10; no tick so the stale sample is replayed
    fork
      get_frame(sd, wsv, clks, nreq, perr);
      cfg_pulse(30, 32'h2);
    join
    chk("f2_data", sd, frame_of(24'hA5A5A5, 24'h5A5A5A));
    chk("f2_len", 64'(clks), 64'd256);
    chk("f2_req", 64'(nreq), 64'd1);
    chk("f2_proto", 64'(perr), 64'd0);

    // 5: tick lands in the reload clock of frame 3
    fork
      get_frame(sd, wsv, clks, nreq, perr);
      tick_pulse(127, 24'h123456, 24'h89ABCD);
    join
    chk("f3_len", 64'(clks), 64'd128);
    chk("f3_ws", wsv, WS_EXP);
    chk("f3_proto", 64'(perr), 64'd0);
    get_frame(sd, wsv, clks, nreq, perr);
    chk("f4_old_sample", sd, frame_of(24'hA5A5A5, 24'h5A5A5A));
    chk("f4_req", 64'(nreq), 64'd1);

    // 4: play drops at bit 10 of frame 5; the frame still completes
    fork
      get_frame(sd, wsv, clks, nreq, perr);
      begin step(21); play_in = 1'b0; end
    join
    chk("f5_new_sample", sd, frame_of(24'h123456, 24'h89ABCD));
    chk("f5_len", 64'(clks), 64'd128);
    chk("f5_ws", wsv, WS_EXP);
    chk("stop_outs", 64'({req_out, ws_out, sck_out, sdo_out}), 64'h0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (req_out || ws_out || sck_out || sdo_out) cnt++;
    end
    chk("stopped_quiet", 64'(cnt), 64'd0);

    // 6: asynchronous reset mid-frame
    play_in = 1'b1;
    step(1);
    chk("restart_req", 64'(req_out), 64'd1);
    step(40);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (sck_out) cnt++;
    end
    chk("active_before_rst", 64'(cnt > 0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 64'({req_out, ws_out, sck_out, sdo_out}), 64'h0);
    play_in = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    play_in = 1'b1;
    step(1);
    chk("post_rst_req", 64'(req_out), 64'd1);
    get_frame(sd, wsv, clks, nreq, perr);
    chk("post_rst_data", sd, 64'h0);
    chk("post_rst_len", 64'(clks), 64'd512);
    chk("post_rst_ws", wsv, WS_EXP);
    chk("post_rst_proto", 64'(perr), 64'd0);
    play_in = 1'b0;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
